// File: rtl/psum_drain.sv
// Column-bottom collector: accumulates four signed psum lanes over acc_len beats into a 2-entry output FIFO.
// Optional saturating arithmetic and sat_flag output when PSUM_DRAIN_SAT_EN is defined.
module psum_drain #(
  parameter int COL_WIDTH = 11,
  parameter int ACC_WIDTH = 20,
  parameter int LEN_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [COL_WIDTH*4-1:0] psum_in,
  input  logic                   psum_valid,
  output logic                   psum_ready,
  input  logic [LEN_WIDTH-1:0]   acc_len,
  input  logic                   fold,
  output logic [ACC_WIDTH*4-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [1:0]             out_count
`ifdef PSUM_DRAIN_SAT_EN
  ,
  output logic                   sat_flag
`endif
);

`ifdef PSUM_DRAIN_SAT_EN
  localparam int ENTRY_W = ACC_WIDTH*4 + 1;
`else
  localparam int ENTRY_W = ACC_WIDTH*4;
`endif

  typedef enum logic [0:0] {IDLE, ACCUM} state_t;

  state_t                 state, state_next;
  logic [ACC_WIDTH-1:0]   acc [4];
  logic [LEN_WIDTH-1:0]   beat_cnt;
  logic [LEN_WIDTH-1:0]   len_q;
  logic                   fold_q;

  logic                   accept;
  logic                   pop;
  logic                   push;
  logic                   last_beat;
  logic                   fold_eff;
  logic [LEN_WIDTH-1:0]   len_eff;
  logic [ACC_WIDTH-1:0]   ext [4];
  logic [ACC_WIDTH-1:0]   addend [4];
  logic [ACC_WIDTH-1:0]   base [4];
  logic [ACC_WIDTH-1:0]   sum [4];
  logic [ENTRY_W-1:0]     entry_in;

  logic [ENTRY_W-1:0]     buf_mem [2];
  logic                   rd_ptr;
  logic                   wr_ptr;
  logic [1:0]             count;

`ifdef PSUM_DRAIN_SAT_EN
  logic                   sat_q;
  logic                   sat_any;
  logic [3:0]             lane_sat;
  logic [ACC_WIDTH:0]     wide [4];
`endif

  assign psum_ready = (count != 2'd2);
  assign accept     = psum_valid && psum_ready;
  assign out_valid  = (count != 2'd0);
  assign out_count  = count;
  assign pop        = out_valid && out_ready;

  // On the first beat of a result, length and fold come straight from the inputs.
  assign fold_eff  = (state == IDLE) ? fold : fold_q;
  assign len_eff   = (state == IDLE) ? ((acc_len == '0) ? LEN_WIDTH'(1) : acc_len) : len_q;
  assign last_beat = (state == IDLE) ? (len_eff == LEN_WIDTH'(1))
                                     : ((beat_cnt + 1'b1) == len_q);
  assign push      = accept && last_beat;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      ext[k]    = {{(ACC_WIDTH-COL_WIDTH){psum_in[k*COL_WIDTH+COL_WIDTH-1]}},
                   psum_in[k*COL_WIDTH +: COL_WIDTH]};
      addend[k] = fold_eff ? '0 : ext[k];
      base[k]   = (state == ACCUM) ? acc[k] : '0;
    end
    if (fold_eff) addend[0] = ext[0] + ext[1] + ext[2] + ext[3];
  end

`ifdef PSUM_DRAIN_SAT_EN
  // Overflow shows up as the two top bits of the widened sum disagreeing.
  always_comb begin
    lane_sat = '0;
    for (int k = 0; k < 4; k++) begin
      wide[k] = {base[k][ACC_WIDTH-1], base[k]} + {addend[k][ACC_WIDTH-1], addend[k]};
      sum[k]  = wide[k][ACC_WIDTH-1:0];
      if (wide[k][ACC_WIDTH] != wide[k][ACC_WIDTH-1]) begin
        lane_sat[k] = 1'b1;
        sum[k] = wide[k][ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                    : {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end
    end
    sat_any  = ((state == ACCUM) && sat_q) || (lane_sat != 4'd0);
    entry_in = {sat_any, sum[3], sum[2], sum[1], sum[0]};
  end
`else
  always_comb begin
    for (int k = 0; k < 4; k++) sum[k] = base[k] + addend[k];
    entry_in = {sum[3], sum[2], sum[1], sum[0]};
  end
`endif

  always_comb begin
    state_next = state;
    if (accept) state_next = last_beat ? IDLE : ACCUM;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      beat_cnt <= '0;
      len_q    <= '0;
      fold_q   <= 1'b0;
      for (int k = 0; k < 4; k++) acc[k] <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        if (state == IDLE) begin
          len_q  <= len_eff;
          fold_q <= fold;
        end
        if (last_beat) begin
          beat_cnt <= '0;
          for (int k = 0; k < 4; k++) acc[k] <= '0;
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
          for (int k = 0; k < 4; k++) acc[k] <= sum[k];
        end
      end
    end
  end

`ifdef PSUM_DRAIN_SAT_EN
  always_ff @(posedge clk) begin
    if (rst) sat_q <= 1'b0;
    else if (accept) sat_q <= last_beat ? 1'b0 : sat_any;
  end
`endif

  // Two-entry FIFO; push never lands on a full buffer since psum_ready gates accepts.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_mem[0] <= '0;
      buf_mem[1] <= '0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      count      <= 2'd0;
    end else begin
      if (push) begin
        buf_mem[wr_ptr] <= entry_in;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      if (push && !pop)      count <= count + 2'd1;
      else if (pop && !push) count <= count - 2'd1;
    end
  end

  assign out_data = buf_mem[rd_ptr][ACC_WIDTH*4-1:0];
`ifdef PSUM_DRAIN_SAT_EN
  assign sat_flag = buf_mem[rd_ptr][ENTRY_W-1];
`endif

endmodule
